example_pipe: RTL
=================

EXAMPLE_PIPE -- requirements
Module: example_pipe

Interface
REQ-001 Parameter CNT_W, default 16: width of the transfer counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_vld  input  1  upstream combinational-decode result valid.
REQ-005 in_rdy  output  1  stage can accept a result this cycle.
REQ-006 in_data  input  7  packed result {cmb_reg5, cmb_reg4, cmb_reg3, cmb_reg2, cmb_reg1[1:0], cmb_reg0}.
REQ-007 out_vld  output  1  registered result available.
REQ-008 out_rdy  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  7  registered result, same packing as in_data.
REQ-010 xfer_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-011 The block SHALL register the upstream combinational results into a 2-entry skid buffer (head register plus skid register), preserving order.
REQ-012 Input transfer SHALL occur when in_vld && in_rdy; output transfer SHALL occur when out_vld && out_rdy.
REQ-013 FSM states SHALL be EMPTY (0 entries), HALF (1, head valid), FULL (2, head and skid valid).
REQ-014 EMPTY: input transfer -> HALF, in_data loaded into head; otherwise stay.
REQ-015 HALF: input only -> FULL, in_data loaded into skid; output only -> EMPTY; input and output together -> stay HALF, in_data loaded into head.
REQ-016 FULL: output transfer -> HALF, skid moved into head; otherwise stay; in_vld ignored.
REQ-017 out_vld SHALL be 1 in HALF and FULL; out_data SHALL equal the head register.
REQ-018 in_rdy SHALL be a registered signal equal to (state != FULL); no combinational path from out_rdy to in_rdy or from in_data to out_data.
REQ-019 Latency: data accepted at edge N SHALL appear on out_data with out_vld=1 in the cycle after edge N when the buffer was EMPTY.
REQ-020 out_data SHALL remain stable while out_vld=1 and out_rdy=0.
REQ-021 in_data presented without a transfer SHALL be discarded; the stage SHALL never drop or duplicate an accepted entry.
REQ-022 Sustained in_vld=out_rdy=1 SHALL give one transfer per cycle with state held at HALF.
REQ-023 xfer_cnt SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.

Reset
REQ-024 On rst_n=0 the block SHALL asynchronously enter EMPTY with out_vld=0, in_rdy=0, out_data=0, skid=0 and xfer_cnt=0.
REQ-025 in_rdy SHALL rise to 1 on the first rising clk edge after rst_n deasserts.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries with no output transfer in that cycle.

Configuration
REQ-027 Macro EXAMPLE_PIPE_XFER_CNT_EN SHALL control the transfer counter.
REQ-028 With EXAMPLE_PIPE_XFER_CNT_EN defined, xfer_cnt SHALL behave per REQ-023.
REQ-029 Without EXAMPLE_PIPE_XFER_CNT_EN, no counter flops SHALL be built, xfer_cnt SHALL be tied to 0, and the port list SHALL be unchanged.

Verification
REQ-030 Reset then single push: in_data=7'h55 with in_vld=1 for one cycle, out_rdy=1 -> out_vld=1 with out_data=7'h55 for exactly one cycle, xfer_cnt=1.
REQ-031 Backpressure: out_rdy=0, push 7'h11 then 7'h22 -> in_rdy=0 after the second push; a third value 7'h33 is not accepted; raising out_rdy yields 7'h11 then 7'h22 in order.
REQ-032 Streaming: in_vld=out_rdy=1 for 100 cycles with an incrementing pattern -> 100 in-order outputs at one per cycle, state HALF throughout, xfer_cnt=100.
REQ-033 Wrap: CNT_W=4, 17 output transfers -> xfer_cnt reads 15 after the 15th transfer, 0 after the 16th, 1 after the 17th; macro undefined -> xfer_cnt stays 0.
REQ-034 Mid-operation reset: FULL with 7'h0A and 7'h0B, pulse rst_n low asynchronously -> out_vld=0 and in_rdy=0 immediately, 7'h0A and 7'h0B never appear on the output.
REQ-035 Random in_vld and out_rdy for 10000 cycles against a scoreboard -> no loss, duplication or reordering, and out_data stable whenever out_vld=1 and out_rdy=0.

Source files
------------

// File: rtl/example_pipe.sv
// example_pipe: 2-entry skid buffer (head + skid) registering a 7-bit decode result, order preserved.
// Latency: 1 cycle from input accept to out_vld when empty; in_rdy is registered (state != FULL).
// Backpressure: holds up to 2 entries under out_rdy=0; EXAMPLE_PIPE_XFER_CNT_EN builds the transfer counter.
module example_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [6:0]       in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [6:0]       out_data,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef struct packed {
    logic       cmb_reg5;
    logic       cmb_reg4;
    logic       cmb_reg3;
    logic       cmb_reg2;
    logic [1:0] cmb_reg1;
    logic       cmb_reg0;
  } res_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  res_t   head;
  res_t   head_nxt;
  res_t   skid;
  res_t   skid_nxt;
  res_t   in_res;
  logic   in_rdy_q;
  logic   in_xfer;
  logic   out_xfer;

  assign in_res   = in_data;
  assign in_rdy   = in_rdy_q;
  assign out_vld  = (state != EMPTY);
  assign out_data = head;
  assign in_xfer  = in_vld && in_rdy_q;
  assign out_xfer = out_vld && out_rdy;

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = HALF;
          head_nxt  = in_res;
        end
      end
      HALF: begin
        if (in_xfer && out_xfer) begin
          head_nxt = in_res;
        end else if (in_xfer) begin
          state_nxt = FULL;
          skid_nxt  = in_res;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_rdy is low here, so only the drain side can move
        if (out_xfer) begin
          state_nxt = HALF;
          head_nxt  = skid;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      head     <= '0;
      skid     <= '0;
      in_rdy_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      head     <= head_nxt;
      skid     <= skid_nxt;
      in_rdy_q <= (state_nxt != FULL);
    end
  end

`ifdef EXAMPLE_PIPE_XFER_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_xfer) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule
